rs232tx_arbiter: RTL



---
 rtl/rs232tx_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rs232tx_arbiter.sv
// rtl/rs232tx_arbiter.sv - round-robin, packet-locking arbiter sharing one rs232tx among NREQ byte sources
module rs232tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023,
  parameter int TO_BITS = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              locked,
  output logic [7:0]        tx_d,
  output logic              tx_we,
  input  logic              tx_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Release fires on the cycle the count would reach TIMEOUT.
  localparam logic [TO_BITS-1:0] TO_LAST = (TIMEOUT > 0) ? TO_BITS'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {ARB, ISSUE, SETTLE, DRAIN} state_t;

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      cand_idx;
  logic [TO_BITS-1:0] to_cnt;
  logic               win_any;
  logic               win_last;
  logic               take;
  logic [7:0]         win_data;
  int                 cand;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    win_any  = 1'b0;
    win_idx  = owner;
    cand     = 0;
    cand_idx = '0;
    if (locked) begin
      win_any = req_valid[owner];
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NREQ) cand = cand - NREQ;
        cand_idx = IW'(cand);
        if (!win_any && req_valid[cand_idx]) begin
          win_any = 1'b1;
          win_idx = cand_idx;
        end
      end
    end
  end

  always_comb begin
    win_data  = 8'h00;
    win_last  = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_data = req_data[8*i +: 8];
        win_last = req_last[i];
      end
    end
    take = (state == ARB) && !tx_busy && win_any;
    if (take) req_ready[win_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ARB;
      grant  <= '0;
      locked <= 1'b0;
      tx_d   <= 8'h00;
      tx_we  <= 1'b0;
      rr_ptr <= '0;
      owner  <= '0;
      to_cnt <= '0;
    end else begin
      tx_we <= 1'b0;
      case (state)
        ARB: begin
          if (take) begin
            tx_d   <= win_data;
            tx_we  <= 1'b1;
            grant  <= req_ready;
            owner  <= win_idx;
            locked <= !win_last;
            to_cnt <= '0;
            if (win_last) rr_ptr <= next_idx(win_idx);
            state  <= ISSUE;
          end else if (locked && !req_valid[owner] && (TIMEOUT > 0)) begin
            if (to_cnt == TO_LAST) begin
              locked <= 1'b0;
              grant  <= '0;
              rr_ptr <= next_idx(owner);
              to_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        ISSUE:  state <= SETTLE;
        // The transmitter only raises busy the cycle after the strobe.
        SETTLE: state <= DRAIN;
        DRAIN: begin
          if (!tx_busy) begin
            state <= ARB;
            if (!locked) grant <= '0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
